// File: rtl/ordena8_stream.sv
// ordena8_stream: streaming 8-byte insertion sorter with valid/ready in and out.
// Define ORDENA8_IDX_EN to carry each byte's arrival index out on out_idx.
module ordena8_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
`ifdef ORDENA8_IDX_EN
  output logic [2:0] out_idx,
`endif
  input  logic       out_ready
);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] count;
  logic [2:0] rd;
  logic [7:0] slot   [8];
  logic [7:0] slot_d [8];
  logic [7:0] le;
  logic       in_hs;
  logic       out_hs;

  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == DRAIN);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_data  = out_valid ? slot[rd] : 8'd0;
  assign out_last  = out_valid && (rd == 3'd7);

  // le is a prefix mask over the sorted slots: entries that stay put
  always_comb begin
    for (int i = 0; i < 8; i++)
      le[i] = (4'(i) < count) && (slot[i] <= in_data);
  end

  always_comb begin
    slot_d[0] = le[0] ? slot[0] : in_data;
    for (int i = 1; i < 8; i++)
      slot_d[i] = le[i] ? slot[i] : (le[i-1] ? in_data : slot[i-1]);
  end

`ifdef ORDENA8_IDX_EN
  logic [2:0] idx   [8];
  logic [2:0] idx_d [8];

  always_comb begin
    idx_d[0] = le[0] ? idx[0] : count[2:0];
    for (int i = 1; i < 8; i++)
      idx_d[i] = le[i] ? idx[i] : (le[i-1] ? count[2:0] : idx[i-1]);
  end

  assign out_idx = out_valid ? idx[rd] : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) idx[i] <= 3'd0;
    end else if (in_hs) begin
      for (int i = 0; i < 8; i++) idx[i] <= idx_d[i];
    end
  end
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      LOAD:    if (in_hs && count == 4'd7) state_d = DRAIN;
      DRAIN:   if (out_hs && out_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      count <= 4'd0;
      rd    <= 3'd0;
      for (int i = 0; i < 8; i++) slot[i] <= 8'd0;
    end else begin
      state <= state_d;
      if (in_hs) begin
        for (int i = 0; i < 8; i++) slot[i] <= slot_d[i];
        count <= count + 4'd1;
        if (count == 4'd7) rd <= 3'd0;
      end
      if (out_hs) begin
        rd <= rd + 3'd1;
        if (out_last) count <= 4'd0;
      end
    end
  end

endmodule
